// File: rtl/gate_probe_pkg.sv
// rtl/gate_probe_pkg.sv - shared types and truth-table constants for the gate prober
package gate_probe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  // Bit i of a truth table is the gate output for a=i[1], b=i[0].
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic       IMPL_AND = 1'b0;
  localparam logic       IMPL_OR  = 1'b1;

endpackage

// File: rtl/gate_prober.sv
// rtl/gate_prober.sv - walks a two-input gate through all four input vectors and classifies it as AND or OR
module gate_prober
  import gate_probe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  input  logic       c_i,
  output logic       busy,
  output logic       done,
  output logic       impl_valid,
  output logic       impl,
  output logic       error,
  output logic [3:0] pattern
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_q, b_q;
  logic             busy_q, done_q;
  logic             valid_q, impl_q, error_q;
  logic [3:0]       pattern_q;

  logic [3:0]       pattern_d;
  logic             valid_d, impl_d, error_d;

  // Classification looks at the table as it will be once the current sample lands.
  always_comb begin
    pattern_d         = pattern_q;
    pattern_d[idx_q]  = c_i;
    valid_d           = 1'b0;
    impl_d            = IMPL_AND;
    error_d           = 1'b1;
    if (pattern_d == TT_AND) begin
      valid_d = 1'b1;
      error_d = 1'b0;
    end else if (pattern_d == TT_OR) begin
      valid_d = 1'b1;
      impl_d  = IMPL_OR;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      impl_q    <= 1'b0;
      error_q   <= 1'b0;
      pattern_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            state_q   <= SETTLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            impl_q    <= 1'b0;
            error_q   <= 1'b0;
            pattern_q <= 4'd0;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            pattern_q <= pattern_d;
            if (idx_q != 2'd3) begin
              idx_q      <= idx_q + 2'd1;
              {a_q, b_q} <= idx_q + 2'd1;
            end else begin
              state_q    <= DONE;
              {a_q, b_q} <= 2'b00;
              done_q     <= 1'b1;
              valid_q    <= valid_d;
              impl_q     <= impl_d;
              error_q    <= error_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= 2'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign impl_valid = valid_q;
  assign impl       = impl_q;
  assign error      = error_q;
  assign pattern    = pattern_q;

endmodule

// File: doc/gate_prober.md
Name: gate_prober

Overview:
- Sequential probe that drives the two inputs of a parameter-selected two-input gate (and2/or2 implementation) and reads back its output.
- Builds the 4-entry truth table and reports which implementation is present: Impl=0 (AND) or Impl=1 (OR).
- Sits in the test-data designs next to the gate, as its checker/reader. Gate output c feeds c_i; a_o/b_o feed gate a/b.

Parameters:
- SETTLE_CYCLES, 2, cycles each input vector is held before c_i is sampled; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a probe run; accepted only in IDLE.
- a_o  output  1  drives gate input a (registered).
- b_o  output  1  drives gate input b (registered).
- c_i  input  1  gate output c; sampled synchronously.
- busy  output  1  high from the accept edge until the end of the DONE cycle.
- done  output  1  one-cycle pulse when the result is updated.
- impl_valid  output  1  result classified as a known implementation.
- impl  output  1  0 = AND truth table, 1 = OR truth table; meaningful only when impl_valid=1.
- error  output  1  truth table matches neither AND nor OR.
- pattern  output  4  captured truth table; bit i = c for vector i, where a=i[1] and b=i[0].

Behaviour:
- Reset (async, any state): state=IDLE; a_o=b_o=0; busy=done=impl_valid=impl=error=0; pattern=0; idx=0; cnt=0.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - start=1 at edge E0 -> SETTLE, idx=0, cnt=0, {a_o,b_o}=2'b00, busy=1.
  - impl_valid, impl, error and pattern clear at E0.
- SETTLE:
  - {a_o,b_o} = idx; cnt increments each edge.
  - On the edge where cnt==SETTLE_CYCLES-1: pattern[idx] <= c_i and cnt <= 0.
  - If idx<3: idx <= idx+1, and a_o/b_o update on the same edge.
  - If idx==3: -> DONE, classify, and a_o=b_o <= 0.
- Sample edges: E0+SETTLE_CYCLES*(k+1), for k=0..3.
- Classification (registered, applied on the edge entering DONE; uses the final sampled bit merged with the earlier bits):
  - 4'b1000 -> impl_valid=1, impl=0, error=0.
  - 4'b1110 -> impl_valid=1, impl=1, error=0.
  - anything else -> impl_valid=0, impl=0, error=1.
- DONE: done=1 and busy=1 for exactly one cycle, then -> IDLE with busy=0 and done=0.
  - Latency: done is high in the cycle beginning at edge E0+4*SETTLE_CYCLES.
- Results (impl_valid, impl, error, pattern) hold in IDLE until the next accepted start.
- start while SETTLE or DONE: ignored, no queuing.
- start held high continuously: a new run is accepted on the first IDLE edge after DONE, i.e. back-to-back runs with one IDLE cycle between them.
- X/unknown on c_i is not handled; the bench must keep c_i defined.
- rst asserted mid-run: immediate return to reset values; the partial pattern is discarded. A run after rst release behaves normally.
- cnt never exceeds SETTLE_CYCLES-1; idx wraps only via return to IDLE.

Decomposition:
- Package gate_probe_pkg holds:
  - state enum {IDLE, SETTLE, DONE};
  - constants TT_AND=4'b1000, TT_OR=4'b1110, IMPL_AND=1'b0, IMPL_OR=1'b1.
- Single module; no sub-module. The settle counter and classifier stay inline; the classifier is a combinational compare against the package constants.

Test Plan:
- gate Impl=0 connected, SETTLE_CYCLES=2, start pulse at edge E0 -> a_o/b_o step 00,01,10,11 every 2 cycles; done in cycle E0+8; pattern=4'b1000, impl_valid=1, impl=0, error=0.
- gate Impl=1 connected, same stimulus -> pattern=4'b1110, impl_valid=1, impl=1, error=0, done one cycle wide.
- c_i tied to 1 -> pattern=4'b1111, error=1, impl_valid=0; next run with a real AND gate clears error at the accept edge.
- start re-pulsed during SETTLE at E0+3 -> ignored; exactly one done at E0+8; start held high -> second run accepted at E0+10.
- rst asserted at E0+5 for 1 cycle -> all outputs 0 immediately, a_o=b_o=0; a fresh start then gives the correct result.
- SETTLE_CYCLES=1 with an OR gate -> vector changes every cycle; done at E0+4; pattern=4'b1110.
